// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART program loader and the instruction memory.
package imem_loader_pkg;

    // Instruction memory geometry, shared with the memory itself.
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    // Frame marker and acknowledge bytes on the UART link.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_OK    = 8'h06;
    localparam logic [7:0] ACK_ERR   = 8'h15;

    // Loader states.
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        ACK
    } state_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte watchdog: counts silent cycles while a frame is in progress and
// flags expiry on the LIMIT-th consecutive silent cycle.
module imem_loader_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    // Silent-cycle counter; held at zero when disabled or when a byte arrives.
    always_ff @(posedge clock) begin
        // NOTE: registers are written with <= so every flop samples the values
        // from before the edge, independent of statement order.
        if (reset || !enable || clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // The current cycle is silent and completes the LIMIT-th silent cycle.
    assign expired = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed program image from the UART into instruction memory and
// arbitrates the memory address between the loader and the CPU fetch path.
// Frame: SYNC, word count N, 4*N data bytes (MSB first), XOR checksum.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int   DEPTH          = IMEM_DEPTH,
    parameter int   ADDR_W         = IMEM_ADDR_W,
    parameter int   TIMEOUT_CYCLES = 1000000,
    parameter logic BOOT_VALID     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic [31:0]       pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              load_error
);

    localparam logic [8:0] DEPTH_LIMIT = 9'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;         // word currently being written
    logic [ADDR_W:0]   n_words;     // words announced in the frame
    logic [ADDR_W:0]   word_cnt;    // words fully received
    logic [1:0]        byte_idx;    // byte position inside the current word
    logic [23:0]       word_lo;     // bytes of the current word received so far
    logic [31:0]       shifted_word;
    logic [7:0]        checksum;
    logic              prog_valid;
    logic              ack_good;
    logic              go_ack;
    logic              ack_ok_next;
    logic              count_ok;
    logic              last_byte;
    logic              timer_enable;
    logic              timeout_expired;
    logic              unused_pc_bits;

    assign shifted_word   = {word_lo, rx_data};
    assign count_ok       = (rx_data != 8'd0) && ({1'b0, rx_data} <= DEPTH_LIMIT);
    assign last_byte      = (byte_idx == 2'd3) && ((word_cnt + 1'b1) == n_words);
    assign timer_enable   = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

    imem_loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .enable  (timer_enable),
        .clear   (rx_valid),
        .expired (timeout_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and acknowledge selection.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        next_state  = state;
        go_ack      = 1'b0;
        ack_ok_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    if (count_ok) begin
                        next_state = DATA;
                    end else begin
                        next_state = ACK;
                        go_ack     = 1'b1;
                    end
                end
            end
            DATA: begin
                // The final word is still written on the following cycle,
                // which may already be a CHECK cycle.
                if (rx_valid && last_byte) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    next_state  = ACK;
                    go_ack      = 1'b1;
                    ack_ok_next = (rx_data == checksum);
                end
            end
            ACK: begin
                if (tx_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (timeout_expired) begin
            next_state  = ACK;
            go_ack      = 1'b1;
            ack_ok_next = 1'b0;
        end
    end

    // Frame datapath: word assembly, checksum, memory writes and load status.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            cpu_restart <= 1'b0;
            load_error  <= 1'b0;
            prog_valid  <= BOOT_VALID;
            ack_good    <= 1'b0;
            ptr         <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            word_lo     <= '0;
            checksum    <= '0;
        end else begin
            mem_we      <= 1'b0;
            cpu_restart <= 1'b0;
            if (mem_we) begin
                ptr <= ptr + 1'b1;
            end
            if (go_ack) begin
                ack_good <= ack_ok_next;
            end
            case (state)
                COUNT: begin
                    if (rx_valid && count_ok) begin
                        n_words  <= rx_data[ADDR_W:0];
                        ptr      <= '0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        checksum <= '0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        word_lo  <= shifted_word[23:0];
                        checksum <= checksum ^ rx_data;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= shifted_word;
                            word_cnt  <= word_cnt + 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (tx_ready) begin
                        prog_valid  <= ack_good;
                        load_error  <= !ack_good;
                        cpu_restart <= ack_good;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address mux, CPU hold and acknowledge output.
    assign mem_addr = (state == IDLE) ? pc[ADDR_W+1:2] : ptr;
    assign cpu_hold = (state != IDLE) || !prog_valid;
    assign tx_valid = (state == ACK);
    assign tx_data  = tx_valid ? (ack_good ? ACK_OK : ACK_ERR) : 8'h00;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader with a frame-level reference model.
module tb_imem_uart_loader;
    import imem_loader_pkg::*;

    localparam int T_CYC = 100;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [31:0] pc;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        cpu_restart;
    logic        load_error;

    always #5 clock = ~clock;

    imem_uart_loader #(
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_restart (cpu_restart),
        .load_error  (load_error)
    );

    int         vectors = 0;
    int         miscompares = 0;
    wr_t        exp_wr[$];
    wr_t        act_wr[$];
    logic [7:0] act_ack[$];
    bit         model_idle = 1'b0;
    bit         model_prog_valid = 1'b1;
    bit         model_load_error = 1'b0;
    bit         first_frame = 1'b1;
    int         exp_restarts = 0;
    int         seen_restarts = 0;
    logic       prev_tv = 1'b0;
    logic       prev_tr = 1'b0;
    logic [7:0] prev_td = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected writes and outcome of one frame (q[0] is SYNC).
    task automatic model_frame(input bq_t q, output bit ok, output bit to);
        int         n;
        logic [7:0] cs;
        wr_t        w;
        ok = 1'b0;
        to = 1'b0;
        n  = int'(q[1]);
        if (n == 0 || n > IMEM_DEPTH) return;
        for (int i = 0; i < n; i++) begin
            if (q.size() >= 2 + 4 * i + 4) begin
                w.addr = 6'(i);
                w.data = {q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]};
                exp_wr.push_back(w);
            end
        end
        if (q.size() < 2 + 4 * n + 1) begin
            to = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) cs ^= q[2+i];
        ok = (q[2+4*n] == cs);
    endtask

    function automatic bq_t build_frame(input int n, input bit corrupt, input bit trunc);
        bq_t        q;
        logic [7:0] cs;
        logic [7:0] b;
        int         k;
        q  = {SYNC_BYTE, 8'(n)};
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b  = 8'($urandom_range(0, 255));
            cs ^= b;
            q.push_back(b);
        end
        if (corrupt) cs ^= 8'($urandom_range(1, 255));
        q.push_back(cs);
        if (trunc) begin
            k = $urandom_range(2, q.size() - 1);
            while (q.size() > k) void'(q.pop_back());
        end
        return q;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        wr_t e;
        wr_t a;
        if (reset) begin
            prev_tv = 1'b0;
            prev_tr = 1'b0;
        end else begin
            if (mem_we) begin
                a.addr = mem_addr;
                a.data = mem_wdata;
                act_wr.push_back(a);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(mem_we), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.addr));
                    check("write_data", mem_wdata, e.data);
                end
            end
            if (prev_tv && !prev_tr) begin
                check("tx_valid_held", 32'(tx_valid), 32'd1);
                check("tx_data_held", 32'(tx_data), 32'(prev_td));
            end
            if (tx_valid && tx_ready) act_ack.push_back(tx_data);
            if (cpu_restart) seen_restarts++;
            if (model_idle) begin
                check("idle_cpu_hold", 32'(cpu_hold), 32'(!model_prog_valid));
                check("idle_mem_addr", 32'(mem_addr), 32'(pc[7:2]));
                check("idle_load_error", 32'(load_error), 32'(model_load_error));
                check("idle_tx_valid", 32'(tx_valid), 32'd0);
            end
            prev_tv = tx_valid;
            prev_tr = tx_ready;
            prev_td = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clock);
            #1 rx_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Idle traffic: random PC and non-SYNC bytes the loader must ignore.
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            pc       = $urandom;
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom_range(0, 255));
            if (rx_data == SYNC_BYTE) rx_data = 8'h00;
        end
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    // mode 0: tx_ready always high; 1: random; 2: low for 10 ack cycles with SYNC spam.
    task automatic run_frame(input bq_t q, input int mode);
        bit ok;
        bit to;
        bit got;
        int silent;
        model_frame(q, ok, to);
        model_idle = 1'b0;
        tx_ready   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], (i == 0) ? 0 : $urandom_range(0, 2));
            if (i == 0) begin
                @(posedge clock);
                #1 rx_valid = 1'b0;
                @(negedge clock);
                check("hold_after_sync", 32'(cpu_hold), 32'd1);
                if (first_frame) check("loader_addr", 32'(mem_addr), 32'd0);
            end
        end
        @(posedge clock);
        #1 rx_valid = 1'b0;
        @(negedge clock);
        if (to) begin
            silent = 0;
            while (!tx_valid && silent < 4 * T_CYC) begin
                silent++;
                @(negedge clock);
            end
            check("timeout_latency", 32'(silent), 32'(T_CYC));
        end else begin
            check("ack_latency", 32'(tx_valid), 32'd1);
        end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (tx_valid && tx_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k >= 9);
            if (mode == 2) begin
                rx_valid = 1'b1;
                rx_data  = SYNC_BYTE;
            end
            @(negedge clock);
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) check("ack_byte", 32'(tx_data), 32'(ok ? ACK_OK : ACK_ERR));
        if (ok) begin
            model_prog_valid = 1'b1;
            model_load_error = 1'b0;
            exp_restarts++;
        end else begin
            model_prog_valid = 1'b0;
            model_load_error = 1'b1;
        end
        @(posedge clock);
        #1;
        rx_valid   = 1'b0;
        tx_ready   = 1'($urandom_range(0, 1));
        model_idle = 1'b1;
        @(negedge clock);
        check("restart_pulse", 32'(cpu_restart), 32'(ok));
        check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        first_frame = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        bq_t q;
        bit  ok;
        bit  to;
        int  r;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        pc       = 32'h8;
        @(negedge clock);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cpu_restart", 32'(cpu_restart), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("boot_mem_addr", 32'(mem_addr), 32'd2);
        check("boot_cpu_hold", 32'(cpu_hold), 32'd0);
        @(posedge clock);
        #1;
        reset      = 1'b0;
        model_idle = 1'b1;
        idle_cycles(3);
        pc = 32'h8;

        // Good two-word load; AE is the XOR of the eight data bytes.
        act_wr.delete();
        act_ack.delete();
        q = {8'hA5, 8'h02, 8'h20, 8'h11, 8'h00, 8'h32, 8'h00, 8'h11, 8'h98, 8'h24, 8'hAE};
        run_frame(q, 0);
        check("good_wr_count", 32'(act_wr.size()), 32'd2);
        if (act_wr.size() >= 2) begin
            check("good_wr0_addr", 32'(act_wr[0].addr), 32'd0);
            check("good_wr0_data", act_wr[0].data, 32'h20110032);
            check("good_wr1_addr", 32'(act_wr[1].addr), 32'd1);
            check("good_wr1_data", act_wr[1].data, 32'h00119824);
        end
        if (act_ack.size() > 0) check("good_ack", 32'(act_ack[act_ack.size()-1]), 32'h06);
        check("good_load_error", 32'(load_error), 32'd0);
        idle_cycles(4);

        // Same frame, wrong checksum.
        act_wr.delete();
        act_ack.delete();
        q[10] = 8'h00;
        run_frame(q, 1);
        check("bad_wr_count", 32'(act_wr.size()), 32'd2);
        if (act_ack.size() > 0) check("bad_ack", 32'(act_ack[act_ack.size()-1]), 32'h15);
        check("bad_load_error", 32'(load_error), 32'd1);
        check("bad_cpu_hold", 32'(cpu_hold), 32'd1);
        idle_cycles(4);

        // Count bounds.
        act_wr.delete();
        act_ack.delete();
        run_frame({8'hA5, 8'h00}, 0);
        run_frame({8'hA5, 8'h41}, 1);
        check("count_err_writes", 32'(act_wr.size()), 32'd0);
        if (act_ack.size() == 2) begin
            check("count0_ack", 32'(act_ack[0]), 32'h15);
            check("count65_ack", 32'(act_ack[1]), 32'h15);
        end else begin
            check("count_err_acks", 32'(act_ack.size()), 32'd2);
        end
        idle_cycles(3);

        // Timeout mid-frame, then a good load under backpressure.
        run_frame({8'hA5, 8'h01, 8'($urandom), 8'($urandom)}, 0);
        idle_cycles(3);
        run_frame(build_frame(3, 1'b0, 1'b0), 2);
        idle_cycles(3);

        // Full-depth image.
        act_wr.delete();
        run_frame(build_frame(64, 1'b0, 1'b0), 1);
        check("full_wr_count", 32'(act_wr.size()), 32'd64);
        if (act_wr.size() == 64) check("full_last_addr", 32'(act_wr[63].addr), 32'd63);
        idle_cycles(3);

        // Random frames: good, corrupted, truncated, out-of-range counts.
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 19);
            if (r == 0) q = {SYNC_BYTE, 8'h00};
            else if (r == 1) q = {SYNC_BYTE, 8'($urandom_range(65, 255))};
            else q = build_frame($urandom_range(1, 6), (r >= 2 && r < 6), (r == 6 || r == 7));
            run_frame(q, $urandom_range(0, 2));
            idle_cycles($urandom_range(1, 5));
        end

        // Reset after six data bytes.
        q = {SYNC_BYTE, 8'h02};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
        model_frame(q, ok, to);
        model_idle = 1'b0;
        for (int i = 0; i < q.size(); i++) send_byte(q[i], $urandom_range(0, 1));
        @(posedge clock);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("pre_reset_writes", 32'(exp_wr.size()), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
        @(posedge clock);
        #1;
        reset            = 1'b0;
        model_prog_valid = 1'b1;
        model_load_error = 1'b0;
        model_idle       = 1'b1;
        idle_cycles(3);

        run_frame(build_frame(2, 1'b0, 1'b0), 1);
        idle_cycles(3);
        check("restart_total", 32'(seen_restarts), 32'(exp_restarts));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
